// File: rtl/riscv_mem_if.sv
// riscv_mem_if: image load stream into the riscv_mem loader.
// Master drives beats and the restart pulse; slave answers with ready.
interface riscv_mem_if #(
  parameter int WIDTH = 32
);
  logic             ld_valid;
  logic             ld_ready;
  logic             ld_sel;
  logic [WIDTH-1:0] ld_data;
  logic             ld_last;
  logic             ld_start;

  modport master (
    output ld_valid,
    output ld_sel,
    output ld_data,
    output ld_last,
    output ld_start,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_sel,
    input  ld_data,
    input  ld_last,
    input  ld_start,
    output ld_ready
  );
endinterface

// File: rtl/riscv_mem.sv
// riscv_mem: imem/dmem responder and image loader for the core.
// Optional RUN cycle counter: define RISCV_MEM_CYCLE_CNT_EN.
module riscv_mem #(
  parameter int WIDTH  = 32,
  parameter int IADDR  = 16,
  parameter int DADDR  = 16,
  parameter int IDEPTH = 1024,
  parameter int DDEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  riscv_mem_if.slave       ld,
  output logic             core_rst_n,
  input  logic [IADDR-1:0] imem_addr,
  output logic [WIDTH-1:0] imem_rdata,
  input  logic [DADDR-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic [3:0]       dmem_wr_en,
  output logic [WIDTH-1:0] dmem_rdata,
  input  logic             fin,
  input  logic [DADDR-1:0] dbg_addr,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic [1:0]       state_o,
  output logic             halted,
  output logic [31:0]      cycles
);

  localparam int IW = $clog2(IDEPTH);
  localparam int DW = $clog2(DDEPTH);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   iptr_q, iptr_d;
  logic [DW-1:0]   dptr_q, dptr_d;
  logic            crst_q;
  logic            beat;

  logic [WIDTH-1:0] imem [IDEPTH];
  logic [WIDTH-1:0] dmem [DDEPTH];

  logic [IW-1:0] iidx;
  logic [DW-1:0] didx;
  logic [DW-1:0] gidx;

  // Upper and byte-offset address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^{imem_addr[1:0], imem_addr[IADDR-1:IW+2],
                         dmem_addr[1:0], dmem_addr[DADDR-1:DW+2],
                         dbg_addr[1:0],  dbg_addr[DADDR-1:DW+2]};

  assign iidx = imem_addr[IW+1:2];
  assign didx = dmem_addr[DW+1:2];
  assign gidx = dbg_addr[DW+1:2];

  assign imem_rdata = imem[iidx];
  assign dmem_rdata = dmem[didx];
  assign dbg_rdata  = dmem[gidx];

  assign ld.ld_ready = (state_q == S_LOAD);
  assign beat        = ld.ld_valid && ld.ld_ready;
  assign core_rst_n  = crst_q;
  assign state_o     = state_q;
  assign halted      = (state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    iptr_d  = iptr_q;
    dptr_d  = dptr_q;
    unique case (1'b1)
      (state_q == S_LOAD): begin
        if (beat) begin
          if (ld.ld_sel) dptr_d = dptr_q + DW'(1);
          else           iptr_d = iptr_q + IW'(1);
          if (ld.ld_last) state_d = S_RUN;
        end
      end
      (state_q == S_RUN): begin
        if (fin) state_d = S_HALT;
      end
      (state_q == S_HALT): begin
        if (ld.ld_start) begin
          state_d = S_LOAD;
          iptr_d  = '0;
          dptr_d  = '0;
        end
      end
      default: begin
        state_d = S_LOAD;
        iptr_d  = '0;
        dptr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      iptr_q  <= '0;
      dptr_q  <= '0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iptr_q  <= iptr_d;
      dptr_q  <= dptr_d;
      crst_q  <= (state_d == S_RUN);
    end
  end

  // Arrays are never cleared, so they sit outside the reset domain.
  always_ff @(posedge clk) begin
    if (beat && !ld.ld_sel) imem[iptr_q] <= ld.ld_data;
  end

  always_ff @(posedge clk) begin
    if (beat && ld.ld_sel) begin
      dmem[dptr_q] <= ld.ld_data;
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_wr_en[i])
          dmem[didx][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

`ifdef RISCV_MEM_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
    end else if (state_q == S_RUN) begin
      if (cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
    end else if (state_q == S_HALT && state_d == S_LOAD) begin
      cyc_q <= '0;
    end
  end

  assign cycles = cyc_q;
`else
  assign cycles = '0;
`endif

endmodule

// File: tb/tb_riscv_mem.sv
// tb_riscv_mem: scoreboard bench for the riscv_mem loader/responder.
// Readback expectations are queued as beats/writes are driven.
module tb_riscv_mem;

`ifdef RISCV_MEM_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_rst_n;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wr_en;
  logic [31:0] dmem_rdata;
  logic        fin;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_rdata;
  logic [1:0]  state_o;
  logic        halted;
  logic [31:0] cycles;

  always #5 clk = ~clk;

  riscv_mem_if #(.WIDTH(32)) ldif ();

  riscv_mem dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld         (ldif),
    .core_rst_n (core_rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wr_en (dmem_wr_en),
    .dmem_rdata (dmem_rdata),
    .fin        (fin),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .state_o    (state_o),
    .halted     (halted),
    .cycles     (cycles)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [15:0] addr;
    logic [31:0] exp;
    string       tag;
  } rd_t;

  rd_t sb[$];

  logic [31:0] imod [1024];
  logic [31:0] dmod [1024];
  int          mip;
  int          mdp;

  bit tb_run = 1'b0;
  int run_edges = 0;

  always @(posedge clk) if (tb_run) run_edges++;

  function automatic void expect_rd(input int port,
                                    input logic [15:0] addr,
                                    input logic [31:0] exp,
                                    input string tag);
    rd_t e;
    e.port = port;
    e.addr = addr;
    e.exp  = exp;
    e.tag  = tag;
    sb.push_back(e);
  endfunction

  task automatic drain();
    rd_t e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        0:       imem_addr = e.addr;
        1:       dmem_addr = e.addr;
        default: dbg_addr  = e.addr;
      endcase
      #1;
      case (e.port)
        0:       got = imem_rdata;
        1:       got = dmem_rdata;
        default: got = dbg_rdata;
      endcase
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic beat(input logic sel,
                      input logic [31:0] d,
                      input logic last);
    @(negedge clk);
    ldif.ld_valid = 1'b1;
    ldif.ld_sel   = sel;
    ldif.ld_data  = d;
    ldif.ld_last  = last;
    if (sel) begin
      dmod[mdp] = d;
      mdp = (mdp + 1) % 1024;
    end else begin
      imod[mip] = d;
      mip = (mip + 1) % 1024;
    end
    @(posedge clk);
    #1;
    ldif.ld_valid = 1'b0;
    ldif.ld_last  = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  initial begin
    logic [31:0] exp_cyc;
    reset_n        = 1'b0;
    imem_addr      = '0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    dmem_wr_en     = '0;
    fin            = 1'b0;
    dbg_addr       = '0;
    ldif.ld_valid  = 1'b0;
    ldif.ld_sel    = 1'b0;
    ldif.ld_data   = '0;
    ldif.ld_last   = 1'b0;
    ldif.ld_start  = 1'b0;
    mip = 0;
    mdp = 0;

    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_core", 32'(core_rst_n), 32'd0);
    chk("rst_ready", 32'(ldif.ld_ready), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    reset_n = 1'b1;

    for (int v = 0; v <= 1024; v++) beat(1'b1, 32'(v), 1'b0);
    beat(1'b1, 32'd1, 1'b0);
    beat(1'b1, 32'd2, 1'b0);
    beat(1'b1, 32'd3, 1'b0);
    beat(1'b1, 32'h1122_3344, 1'b0);
    chk("load_state", 32'(state_o), 32'd0);
    chk("load_core", 32'(core_rst_n), 32'd0);

    beat(1'b0, 32'h0000_0013, 1'b0);
    beat(1'b0, 32'h0010_0093, 1'b0);
    chk("pre_last_core", 32'(core_rst_n), 32'd0);
    beat(1'b0, 32'h0000_8067, 1'b1);
    tb_run = 1'b1;
    chk("run_core", 32'(core_rst_n), 32'd1);
    chk("run_state", 32'(state_o), 32'd1);
    chk("run_ready", 32'(ldif.ld_ready), 32'd0);

    for (int w = 0; w < 3; w++)
      expect_rd(0, 16'(w * 4), imod[w], "imem_word");
    expect_rd(0, 16'h0008, 32'h0000_8067, "imem_0x8");
    expect_rd(0, 16'h1008, imod[2], "imem_alias");
    for (int w = 0; w < 5; w++) begin
      expect_rd(1, 16'(w * 4), dmod[w], "dmem_word");
      expect_rd(2, 16'(w * 4), dmod[w], "dbg_word");
    end
    expect_rd(2, 16'h0000, 32'd1024, "wrap_w0");
    expect_rd(2, 16'h0004, 32'd1, "wrap_w1");
    drain();

    @(negedge clk);
    dmem_addr  = 16'h0010;
    dmem_wdata = 32'hAABB_CCDD;
    dmem_wr_en = 4'b0101;
    #1;
    chk("rd_old", dmem_rdata, dmod[4]);
    @(posedge clk);
    #1;
    dmem_wr_en = 4'b0000;
    dmod[4] = merge(dmod[4], 32'hAABB_CCDD, 4'b0101);
    expect_rd(1, 16'h0010, dmod[4], "byte_merge");
    expect_rd(1, 16'h0010, 32'h11BB_33DD, "byte_const");
    drain();

    @(negedge clk);
    ldif.ld_start = 1'b1;
    @(posedge clk);
    #1;
    ldif.ld_start = 1'b0;
    chk("start_in_run", 32'(state_o), 32'd1);

    while (run_edges < 99) @(negedge clk);
    fin        = 1'b1;
    dmem_addr  = 16'h0020;
    dmem_wdata = 32'hDEAD_BEEF;
    dmem_wr_en = 4'b1111;
    @(posedge clk);
    #1;
    fin        = 1'b0;
    dmem_wr_en = 4'b0000;
    tb_run     = 1'b0;
    dmod[8]    = 32'hDEAD_BEEF;
    exp_cyc    = CNT_EN ? 32'(run_edges) : 32'd0;
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_state", 32'(state_o), 32'd2);
    chk("halt_core", 32'(core_rst_n), 32'd0);
    chk("halt_cycles", cycles, CNT_EN ? 32'd100 : 32'd0);
    expect_rd(2, 16'h0020, 32'hDEAD_BEEF, "fin_write");

    @(negedge clk);
    dmem_wdata = 32'h1234_5678;
    dmem_wr_en = 4'b1111;
    @(posedge clk);
    #1;
    dmem_wr_en = 4'b0000;
    expect_rd(2, 16'h0020, dmod[8], "halt_nowrite");
    drain();
    chk("halt_hold_cyc", cycles, exp_cyc);

    @(negedge clk);
    ldif.ld_start = 1'b1;
    @(posedge clk);
    #1;
    ldif.ld_start = 1'b0;
    mip = 0;
    mdp = 0;
    chk("restart_state", 32'(state_o), 32'd0);
    chk("restart_ready", 32'(ldif.ld_ready), 32'd1);
    chk("restart_cycles", cycles, 32'd0);
    chk("restart_halted", 32'(halted), 32'd0);

    beat(1'b0, 32'hCAFE_F00D, 1'b0);
    beat(1'b1, 32'h0BAD_BEEF, 1'b0);
    expect_rd(0, 16'h0000, imod[0], "reload_i0");
    expect_rd(0, 16'h0004, 32'h0010_0093, "keep_i1");
    expect_rd(2, 16'h0000, dmod[0], "reload_d0");
    expect_rd(2, 16'h0004, 32'd1, "keep_d1");
    drain();

    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_load_state", 32'(state_o), 32'd0);
    chk("arst_load_core", 32'(core_rst_n), 32'd0);
    #1;
    reset_n = 1'b1;
    mip = 0;
    mdp = 0;

    beat(1'b1, 32'h0000_0055, 1'b1);
    tb_run = 1'b1;
    chk("rerun_core", 32'(core_rst_n), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    tb_run = 1'b0;
    chk("arst_run_core", 32'(core_rst_n), 32'd0);
    chk("arst_run_state", 32'(state_o), 32'd0);
    chk("arst_run_cyc", cycles, 32'd0);
    #1;
    reset_n = 1'b1;

    expect_rd(2, 16'h0000, dmod[0], "ptr_cleared");
    expect_rd(2, 16'h0004, dmod[1], "keep_d1b");
    expect_rd(2, 16'h0020, dmod[8], "keep_d8");
    expect_rd(0, 16'h0000, imod[0], "keep_i0");
    expect_rd(0, 16'h0008, imod[2], "keep_i2");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mem.md
# riscv_mem

Memory responder and program loader for the single-cycle RISC-V core. Serves the core's instruction-fetch and data ports with combinational reads and byte-enabled synchronous writes. Holds the core in reset while a valid/ready stream loads instruction and data images, then releases the core and captures halt on `fin`. Sits beside the core at SoC top level; the testbench or a host bridge drives the load stream.

## Interface
- `WIDTH`, 32: data word width; only 32 is supported.
- `IADDR`, 16: core instruction byte-address width.
- `DADDR`, 16: core data byte-address width.
- `IDEPTH`, 1024: instruction memory depth in words; power of two.
- `DDEPTH`, 1024: data memory depth in words; power of two.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `core_rst_n` out 1: reset to the core; low except in RUN.
- `imem_addr` in IADDR: core fetch byte address.
- `imem_rdata` out WIDTH: fetched instruction word.
- `dmem_addr` in DADDR: core data byte address.
- `dmem_wdata` in WIDTH: core store data.
- `dmem_wr_en` in 4: per-byte write enables.
- `dmem_rdata` out WIDTH: load data, full word.
- `fin` in 1: core halt indication.
- `ld_valid` in 1: load beat valid.
- `ld_ready` out 1: loader can accept a beat.
- `ld_sel` in 1: beat target; 0 = imem, 1 = dmem.
- `ld_data` in WIDTH: beat word.
- `ld_last` in 1: final beat of the image.
- `ld_start` in 1: restart request from HALT.
- `dbg_addr` in DADDR: debug read byte address into dmem.
- `dbg_rdata` out WIDTH: debug read data.
- `state_o` out 2: state, encoded LOAD=0, RUN=1, HALT=2.
- `halted` out 1: high in HALT.
- `cycles` out 32: run-cycle count (see Configuration).

## Operation
- Word index: `imem_addr[log2(IDEPTH)+1:2]` and `dmem_addr[log2(DDEPTH)+1:2]`. Bits [1:0] and upper bits are ignored, so out-of-range addresses alias.
- Reads of imem, dmem and debug are combinational from the arrays in every state.
- State machine: reset enters LOAD.
- **LOAD**
  - `ld_ready`=1; a beat transfers when `ld_valid && ld_ready`.
  - The beat writes `ld_data` at `iptr` when `ld_sel`=0, or at `dptr` when `ld_sel`=1.
  - The selected pointer then increments, wrapping at its depth to 0.
  - An accepted beat with `ld_last`=1 moves the state to RUN.
  - Core writes are ignored.
- **RUN**
  - `core_rst_n`=1 and `ld_ready`=0.
  - For each i with `dmem_wr_en[i]`=1, byte i (bits 8i+7:8i) of the addressed word is written at the clock edge.
  - `fin`=1 moves the state to HALT. A write in the same cycle as `fin` still commits.
- **HALT**
  - `core_rst_n`=0 and `halted`=1; core writes are ignored.
  - `ld_start`=1 moves the state to LOAD and clears `iptr` and `dptr` to 0.
- Entering LOAD from HALT or from reset clears both pointers. Memory contents are never cleared.
- Outside HALT, `ld_start` is ignored.

## Timing
- Reset values: state LOAD, `core_rst_n`=0, `ld_ready`=1, `halted`=0, `state_o`=0, `cycles`=0, pointers 0.
- `core_rst_n` is registered. It rises the cycle after the `ld_last` acceptance edge and falls the cycle after the `fin` edge.
- Asserting `reset_n` mid-operation drops `core_rst_n` asynchronously.
- Write latency: data is visible on the combinational read one edge after the write cycle.
- A read to the same word in the write cycle returns the old data.
- `ld_ready` depends only on state; there is no combinational path from `ld_valid`.

## Configuration
- `RISCV_MEM_CYCLE_CNT_EN`
  - Defined: `cycles` increments every clock edge in RUN, saturates at 0xFFFFFFFF, holds in HALT, and clears on entry to LOAD.
  - Undefined: no counter logic; `cycles` is tied to 0.

## Test plan
- Load 3 imem beats 0x00000013, 0x00100093, 0x00008067 with `ld_last` on the third -> imem words 0..2 hold these values; `core_rst_n` rises the next cycle; `imem_addr`=0x8 reads 0x00008067.
- In RUN, `dmem_addr`=0x10, `dmem_wdata`=0xAABBCCDD, `dmem_wr_en`=4'b0101 on a word holding 0x11223344 -> `dmem_rdata` reads 0x11BB33DD on the next cycle.
- Load 1025 dmem beats with values 0..1024 (DDEPTH=1024) -> `dptr` wraps; word 0 reads 1024 and word 1 reads 1.
- Assert `fin` together with a write of 0xDEADBEEF to 0x20 -> the write commits; `halted`=1 next cycle; `dbg_addr`=0x20 reads 0xDEADBEEF; later core writes are ignored.
- From HALT, pulse `ld_start`, then drop `reset_n` mid-load -> LOAD, pointers 0, `core_rst_n`=0 immediately, prior memory contents retained.
- With `RISCV_MEM_CYCLE_CNT_EN` defined, hold RUN for 100 cycles then assert `fin` -> `cycles`=100 and stays 100 in HALT; re-entering LOAD clears it to 0.
